// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: divider FSM states and datapath widths.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned HALF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {rem, dividend}.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] dividend_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  // The new quotient bit enters the dividend LSB as the dividend shifts out.
  always_comb begin
    shifted       = {rem, dividend[WIDTH-1]};
    q_bit         = (shifted >= (WIDTH+2)'(divisor));
    trial         = (WIDTH+1)'(shifted - (WIDTH+2)'(divisor));
    rem_next      = q_bit ? trial : shifted[WIDTH:0];
    dividend_next = {dividend[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with byte mode and divide-by-zero flag.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             half_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             z
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_FULL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_WIDTH - 1);

  div_state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             half_r;
  logic             dz_r;

  logic [WIDTH-1:0] a_eff_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] a_top_c;
  logic [WIDTH:0]   rem_step_c;
  logic [WIDTH-1:0] dvd_step_c;
  logic             last_c;

  // Byte mode: dividend is pre-aligned to the top so 8 steps leave the quotient in the low byte.
  always_comb begin
    a_eff_c = half_mode ? WIDTH'(a[HALF_WIDTH-1:0]) : a;
    b_eff_c = half_mode ? WIDTH'(b[HALF_WIDTH-1:0]) : b;
    a_top_c = half_mode ? (WIDTH'(a[HALF_WIDTH-1:0]) << (WIDTH - HALF_WIDTH)) : a;
    last_c  = (cnt == (half_r ? LAST_HALF : LAST_FULL));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem           (rem),
    .dividend      (dvd),
    .divisor       (dsr),
    .rem_next      (rem_step_c),
    .dividend_next (dvd_step_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (b_eff_c == '0) ? ZERO : RUN;
      RUN:     if (last_c) state_next = DONE;
      ZERO:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers; a zero divisor latches its fixed results directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      half_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            dsr    <= b_eff_c;
            half_r <= half_mode;
            if (b_eff_c == '0) begin
              dvd  <= half_mode ? WIDTH'({HALF_WIDTH{1'b1}}) : '1;
              rem  <= (WIDTH+1)'(a_eff_c);
              dz_r <= 1'b1;
            end else begin
              dvd  <= a_top_c;
              rem  <= '0;
              dz_r <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_step_c;
          dvd <= dvd_step_c;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Visible outputs only change as the DONE state retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      z         <= 1'b0;
    end else begin
      busy <= (state_next == RUN) || (state_next == ZERO);
      done <= (state == DONE);
      if (state == DONE) begin
        quotient  <= dvd;
        remainder <= rem[WIDTH-1:0];
        div_zero  <= dz_r;
        z         <= half_r ? (dvd[HALF_WIDTH-1:0] == '0) : (dvd == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        half_mode;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_zero, z;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .half_mode (half_mode),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .z         (z)
  );

  always #5 clk = ~clk;

  // Reference model: what is visible after each rising edge.
  int          edge_n = 0;
  bit          m_inflight = 0;
  int          m_start_edge = 0, m_done_edge = 0, m_accept_from = 0, m_lat = 0;
  logic [15:0] p_q = '0, p_r = '0;
  logic        p_dz = 1'b0;
  logic [15:0] m_q = '0, m_r = '0;
  logic        m_dz = 1'b0, m_z = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] ae, be;
    if (!rst_n) begin
      edge_n = 0; m_inflight = 0; m_accept_from = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0; m_z = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      edge_n++;
      m_done = 1'b0;
      if (m_inflight && edge_n == m_done_edge) begin
        m_q = p_q; m_r = p_r; m_dz = p_dz; m_z = (p_q == 16'h0);
        m_done = 1'b1;
        m_inflight = 0;
      end
      if (!m_inflight && start && edge_n >= m_accept_from) begin
        ae = half_mode ? {8'h00, a[7:0]} : a;
        be = half_mode ? {8'h00, b[7:0]} : b;
        if (be == 16'h0) begin
          p_q = half_mode ? 16'h00FF : 16'hFFFF; p_r = ae; p_dz = 1'b1; m_lat = 2;
        end else begin
          p_q = ae / be; p_r = ae % be; p_dz = 1'b0; m_lat = half_mode ? 9 : 17;
        end
        m_inflight    = 1;
        m_start_edge  = edge_n;
        m_done_edge   = edge_n + m_lat;
        m_accept_from = edge_n + m_lat + 1;
      end
      m_busy = m_inflight && (edge_n <= m_start_edge + m_lat - 2);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({busy, done, div_zero, z, quotient, remainder} !==
          {m_busy, m_done, m_dz, m_z, m_q, m_r}) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got busy=%b done=%b dz=%b z=%b q=%h r=%h, expected busy=%b done=%b dz=%b z=%b q=%h r=%h",
                 $time, busy, done, div_zero, z, quotient, remainder,
                 m_busy, m_done, m_dz, m_z, m_q, m_r);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One operation with hand-computed results; optionally re-pulses start mid-run.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ih,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input logic ez, input int elat, input bit interfere);
    int cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; half_mode = ih;
    cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      start = interfere && (cnt == 3);
      if (interfere && cnt == 3) begin
        a = 16'h0005; b = 16'h0001; half_mode = 1'b1;
      end
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected latency %0d", cnt, elat);
    end else begin
      check_lit("latency", 32'(cnt - 1), 32'(elat));
      check_lit("quotient", {16'h0, quotient}, {16'h0, eq});
      check_lit("remainder", {16'h0, remainder}, {16'h0, er});
      check_lit("div_zero", {31'h0, div_zero}, {31'h0, edz});
      check_lit("z", {31'h0, z}, {31'h0, ez});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; half_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    check_lit("reset_quotient", {16'h0, quotient}, 32'h0);
    check_lit("reset_flags", {28'h0, busy, done, div_zero, z}, 32'h0);

    run_op(16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 17, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 0);
    run_op(16'h1234, 16'hFFFF, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1, 17, 0);
    run_op(16'hAB37, 16'h0005, 1'b1, 16'h000B, 16'h0000, 1'b0, 1'b0, 9,  0);
    run_op(16'd0,    16'd9,    1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 17, 0);
    run_op(16'h1234, 16'h0500, 1'b1, 16'h00FF, 16'h0034, 1'b1, 1'b0, 2,  0);
    run_op(16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 17, 1);
    run_op(16'd42,   16'd0,    1'b0, 16'hFFFF, 16'd42,   1'b1, 1'b0, 2,  0);

    // Abort mid-run: outputs held from the last result must clear at once.
    @(negedge clk);
    start = 1'b1; a = 16'd1000; b = 16'd3; half_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_lit("abort_quotient", {16'h0, quotient}, 32'h0);
    check_lit("abort_remainder", {16'h0, remainder}, 32'h0);
    check_lit("abort_flags", {28'h0, busy, done, div_zero, z}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_op(16'd200, 16'd13, 1'b0, 16'd15, 16'd5, 1'b0, 1'b0, 17, 0);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start     = ($urandom_range(2) == 0);
      a         = 16'($urandom);
      half_mode = $urandom_range(1) == 1;
      case ($urandom_range(7))
        0:       b = 16'h0000;
        1:       b = 16'h0001;
        2:       b = 16'($urandom_range(15));
        3:       b = 16'($urandom) & 16'hFF00;
        default: b = 16'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
